// File: rtl/key_capture_avs.sv
// key_capture_avs: debounced pushbutton capture with Avalon-MM registers and interrupt
module key_capture_avs #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_n,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);
    logic [WIDTH-1:0] sync1, sync2, pressed, stable, differ, done, press, irqmask, edgecap, w1c;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [15:0]      evcount;
    logic [31:0]      rdata;
    logic             unused;
    assign unused  = ^avs_writedata[31:WIDTH];
    assign pressed = ~sync2;
    assign press   = done & pressed;
    assign w1c     = (avs_write && avs_address == 2'd2) ? avs_writedata[WIDTH-1:0] : '0;
    // per-key mismatch and terminal-count detection
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            differ[i] = pressed[i] ^ stable[i];
            done[i]   = differ[i] && cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1);
        end
    end
    // read mux; unused bits are zero
    always_comb begin
        rdata = avs_address == 2'd0 ? 32'(stable) :
                avs_address == 2'd1 ? 32'(irqmask) :
                avs_address == 2'd2 ? 32'(edgecap) : 32'(evcount);
    end
    // two-flop synchronizer; idle keys are high on key_n
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end
    // independent debounce per key: stable follows after DEBOUNCE_CYCLES of disagreement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= (differ[i] && !done[i]) ? cnt[i] + CNT_W'(1) : '0;
                if (done[i]) stable[i] <= pressed[i];
            end
        end
    end
    // register file: press set beats W1C, EVCOUNT saturates and restarts at 1 on a coincident press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask <= '0;
            edgecap <= '0;
            evcount <= '0;
        end else begin
            if (avs_write && avs_address == 2'd1) irqmask <= avs_writedata[WIDTH-1:0];
            edgecap <= (edgecap & ~w1c) | press;
            if (avs_write && avs_address == 2'd3) evcount <= |press ? 16'd1 : 16'd0;
            else if (|press && evcount != 16'hFFFF) evcount <= evcount + 16'd1;
        end
    end
    // latency-1 read data held between reads, registered interrupt
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (avs_read) avs_readdata <= rdata;
            irq <= |(edgecap & irqmask);
        end
    end
endmodule

// File: tb/tb_key_capture_avs.sv
// tb_key_capture_avs: scoreboard bench for key_capture_avs with a short debounce
module tb_key_capture_avs;
    logic        clk = 0, reset = 1, avs_read = 0, avs_write = 0, irq, rd_q = 0;
    logic [3:0]  key_n = 4'hF;
    logic [1:0]  avs_address = 0;
    logic [31:0] avs_writedata = 0, avs_readdata;
    logic [31:0] exp_q [$];
    string       nm_q [$];
    int          checks = 0, errors = 0;

    key_capture_avs #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_q <= avs_read;

    // monitor: every read response is compared against the oldest expectation
    always @(negedge clk) begin
        if (rd_q) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: got %h, no expectation queued", avs_readdata);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                automatic string n = nm_q.pop_front();
                if (avs_readdata !== e) begin
                    errors++;
                    $display("FAIL %s: got %h, expected %h", n, avs_readdata, e);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", n, act, e);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
        avs_address = a;
        avs_read = 1;
        exp_q.push_back(e);
        nm_q.push_back(n);
        tick(1);
        avs_read = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1;
        tick(1);
        avs_write = 0;
    endtask

    task automatic rdwr(input logic [1:0] a, input logic [31:0] d, input logic [31:0] e, input string n);
        avs_address = a;
        avs_writedata = d;
        avs_write = 1;
        avs_read = 1;
        exp_q.push_back(e);
        nm_q.push_back(n);
        tick(1);
        avs_write = 0;
        avs_read = 0;
    endtask

    task automatic press(input int k, input int hold);
        key_n[k] = 0;
        tick(hold);
        key_n[k] = 1;
        tick(12);
    endtask

    initial begin
        tick(3);
        reset = 0;
        rd(0, 0, "rst_data");
        rd(1, 0, "rst_irqmask");
        rd(2, 0, "rst_edgecap");
        rd(3, 0, "rst_evcount");
        chk("rst_irq", 32'(irq), 0);
        // clean press on key 0: DATA changes on the 6th edge after the drive
        key_n[0] = 0;
        tick(5);
        rd(0, 0, "data_before_edge6");
        rd(0, 1, "data_after_edge6");
        tick(13);
        key_n[0] = 1;
        tick(12);
        rd(2, 1, "press_edgecap");
        rd(3, 1, "press_evcount");
        chk("press_irq_masked", 32'(irq), 0);
        rd(0, 0, "release_data");
        wr(2, 1);
        wr(3, 0);
        rd(2, 0, "w1c_clear");
        rd(3, 0, "evcount_clear");
        // bounce on key 1 never survives the debounce window
        for (int i = 0; i < 15; i++) begin
            key_n[1] = ~key_n[1];
            tick(2);
        end
        key_n[1] = 1;
        tick(10);
        rd(0, 0, "bounce_data");
        rd(2, 0, "bounce_edgecap");
        rd(3, 0, "bounce_evcount");
        // interrupt path on key 2, plus read-during-write returns the old value
        rdwr(1, 4, 0, "rdwr_old_irqmask");
        rd(1, 4, "irqmask");
        key_n[2] = 0;
        tick(6);
        chk("irq_lag", 32'(irq), 0);
        tick(1);
        chk("irq_set", 32'(irq), 1);
        key_n[2] = 1;
        tick(12);
        wr(2, 4);
        chk("irq_hold_after_w1c", 32'(irq), 1);
        tick(1);
        chk("irq_cleared", 32'(irq), 0);
        rd(2, 0, "edgecap2_cleared");
        // W1C on the exact press cycle of key 3 loses to the set
        key_n[3] = 0;
        tick(5);
        wr(2, 8);
        tick(6);
        key_n[3] = 1;
        tick(12);
        rd(2, 8, "w1c_race");
        rd(3, 2, "evcount_two");
        chk("irq_unmasked_bit", 32'(irq), 0);
        // saturation: force press events to preload 0xFFFE
        wr(2, 15);
        wr(3, 0);
        force dut.press = 4'b0001;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        release dut.press;
        rd(3, 32'hFFFE, "evcount_preload");
        press(0, 10);
        press(0, 10);
        rd(3, 32'hFFFF, "evcount_saturated");
        wr(3, 0);
        rd(3, 0, "evcount_write_clear");
        key_n[0] = 0;
        tick(5);
        wr(3, 0);
        tick(4);
        key_n[0] = 1;
        tick(12);
        rd(3, 1, "evcount_write_on_press");
        // reset in the middle of a debounce with the key still held
        wr(1, 0);
        key_n[0] = 0;
        tick(4);
        reset = 1;
        tick(1);
        chk("reset_readdata", avs_readdata, 0);
        chk("reset_irq", 32'(irq), 0);
        tick(1);
        reset = 0;
        rd(0, 0, "post_rst_data");
        rd(1, 0, "post_rst_irqmask");
        rd(2, 0, "post_rst_edgecap");
        rd(3, 0, "post_rst_evcount");
        tick(1);
        rd(0, 0, "held_data_before");
        rd(0, 1, "held_data_after");
        rd(2, 1, "held_edgecap");
        rd(3, 1, "held_evcount");
        key_n[0] = 1;
        tick(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
